// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the register-file slave.
// Holds response encodings, bus widths, the W-channel payload layout and a
// byte-strobe merge helper used when committing a write.
package axi_lite_pkg;

    localparam int unsigned AXI_RESP_W = 2;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

    // One W-channel beat as held in the write-data slot.
    typedef struct packed {
        logic [AXI_STRB_W-1:0] strb;
        logic [AXI_DATA_W-1:0] data;
    } w_beat_t;

    // Replace only the bytes of cur whose strobe bit is set.
    function automatic logic [AXI_DATA_W-1:0] apply_wstrb(
        input logic [AXI_DATA_W-1:0] cur,
        input logic [AXI_DATA_W-1:0] wdata,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] res;
        res = cur;
        for (int k = 0; k < int'(AXI_STRB_W); k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = wdata[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_slot.sv
// One-entry, valid-tagged holding register.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, empties the slot
//   load  - capture d and mark the slot full
//   clear - mark the slot empty (payload is left as-is)
//   d     - payload to capture
//   full  - slot holds a payload
//   q     - held payload
module axi_lite_slot
    import axi_lite_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         full,
    output logic [W-1:0] q
);

    // Load only happens when empty and clear only when full, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            q    <= '0;
        end else if (load) begin
            full <= 1'b1;
            q    <= d;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
// Write address and write data are captured independently into one-entry
// slots; the write commits once both slots are full and no write response is
// pending. Reads are single-outstanding and return the value held before the
// accepting edge. Unmapped indices respond SLVERR (reads return zero).
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET        - clock, synchronous active-high reset
//   S_AXI_AW*, S_AXI_W*, S_AXI_B*   - write address / data / response channels
//   S_AXI_AR*, S_AXI_R*             - read address / data channels
//   regs_o                          - all register contents, reg i at [32i+31:32i]
module axi_lite_regfile_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS           = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,

    output logic [AXI_RESP_W-1:0]                  S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [AXI_RESP_W-1:0]                  S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,

    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o
);

    localparam int unsigned ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned BEAT_W = $bits(w_beat_t);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // ------------------------------------------------------------------
    // Write address / data slots
    // ------------------------------------------------------------------
    logic              aw_full;
    logic [ADDR_W-1:0] aw_addr_q;
    logic              w_full;
    w_beat_t           w_beat_q;
    w_beat_t           w_beat_in_c;
    logic              aw_load_c;
    logic              w_load_c;
    logic              commit_c;

    // READY depends only on slot state and reset, never on VALID.
    assign S_AXI_AWREADY = ~aw_full & ~S_AXI_ARESET;
    assign S_AXI_WREADY  = ~w_full  & ~S_AXI_ARESET;

    assign aw_load_c = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_load_c  = S_AXI_WVALID  & S_AXI_WREADY;

    // A pending B response blocks the commit; full slots then backpressure.
    assign commit_c = aw_full & w_full & ~S_AXI_BVALID;

    assign w_beat_in_c = '{strb: S_AXI_WSTRB, data: S_AXI_WDATA};

    axi_lite_slot #(.W(ADDR_W)) u_aw_slot (
        .clk   (S_AXI_ACLK),
        .rst   (S_AXI_ARESET),
        .load  (aw_load_c),
        .clear (commit_c),
        .d     (S_AXI_AWADDR),
        .full  (aw_full),
        .q     (aw_addr_q)
    );

    axi_lite_slot #(.W(BEAT_W)) u_w_slot (
        .clk   (S_AXI_ACLK),
        .rst   (S_AXI_ARESET),
        .load  (w_load_c),
        .clear (commit_c),
        .d     (w_beat_in_c),
        .full  (w_full),
        .q     (w_beat_q)
    );

    // ------------------------------------------------------------------
    // Address decode (byte offset bits are ignored)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] wr_idx_c;
    logic [IDX_W-1:0] rd_idx_c;
    logic             wr_mapped_c;
    logic             rd_mapped_c;

    assign wr_idx_c    = aw_addr_q[ADDR_W-1:2];
    assign rd_idx_c    = S_AXI_ARADDR[ADDR_W-1:2];
    assign wr_mapped_c = 32'(wr_idx_c) < NUM_REGS;
    assign rd_mapped_c = 32'(rd_idx_c) < NUM_REGS;

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit_c) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (wr_idx_c == IDX_W'(i)) begin
                    regs_q[i] <= apply_wstrb(regs_q[i], w_beat_q.data, w_beat_q.strb);
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs_out
        assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

    // ------------------------------------------------------------------
    // Write response channel
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
        end else if (commit_c) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_mapped_c ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic              ar_hs_c;
    logic [DATA_W-1:0] rd_word_c;

    assign S_AXI_ARREADY = ~S_AXI_RVALID & ~S_AXI_ARESET;
    assign ar_hs_c       = S_AXI_ARVALID & S_AXI_ARREADY;

    // Unmapped indices fall through to zero.
    always_comb begin
        rd_word_c = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (rd_idx_c == IDX_W'(i)) begin
                rd_word_c = regs_q[i];
            end
        end
    end

    // Sampling regs_q here yields the pre-commit value on a same-edge write.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
        end else if (ar_hs_c) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_word_c;
            S_AXI_RRESP  <= rd_mapped_c ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

    // Protection bits and byte offsets carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr_q[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed self-checking bench for axi_lite_regfile_slave.
module tb_axi_lite_regfile_slave;
    import axi_lite_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 4;

    logic              tb_ACLK = 1'b0;
    logic              areset;
    logic [AW-1:0]     awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AW-1:0]     araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [NR*DW-1:0]  regs;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_regs [NR];

    always #5 tb_ACLK = ~tb_ACLK;

    axi_lite_regfile_slave #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (NR)
    ) dut (
        .S_AXI_ACLK    (tb_ACLK),
        .S_AXI_ARESET  (areset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .regs_o        (regs)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < int'(NR); i++) begin
            check_val($sformatf("%s reg%0d", tag, i), regs[i*32 +: 32], exp_regs[i]);
        end
    endtask

    // Called and returns on a falling edge.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_done, w_done, aw_hs, w_hs;
        int   cnt;
        aw_done = 1'b0; w_done = 1'b0; cnt = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && cnt < 20) begin
            aw_hs = awvalid & awready;
            w_hs  = wvalid & wready;
            @(negedge tb_ACLK);
            if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
            cnt++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        cnt = 0;
        while (!bvalid && cnt < 20) begin
            @(negedge tb_ACLK);
            cnt++;
        end
        check_val("write bvalid", 32'(bvalid), 32'd1);
        resp = bresp;
        bready = 1'b1;
        @(negedge tb_ACLK);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int cnt;
        cnt = 0;
        araddr = addr; arvalid = 1'b1;
        while (!arready && cnt < 20) begin
            @(negedge tb_ACLK);
            cnt++;
        end
        @(negedge tb_ACLK);
        arvalid = 1'b0;
        cnt = 0;
        while (!rvalid && cnt < 20) begin
            @(negedge tb_ACLK);
            cnt++;
        end
        check_val("read rvalid", 32'(rvalid), 32'd1);
        data = rdata;
        resp = rresp;
        rready = 1'b1;
        @(negedge tb_ACLK);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] vals [4];
        logic [31:0] rd;
        logic [1:0]  rsp;

        vals[0] = 32'h0101FFFF; vals[1] = 32'habcd0001;
        vals[2] = 32'hdead0011; vals[3] = 32'hbeef0011;
        for (int i = 0; i < int'(NR); i++) exp_regs[i] = 32'h0;

        areset = 1'b1;
        awaddr = '0; awprot = 3'b0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = 3'b0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        repeat (3) @(negedge tb_ACLK);
        check_val("rst awready", 32'(awready), 32'd0);
        check_val("rst wready", 32'(wready), 32'd0);
        check_val("rst arready", 32'(arready), 32'd0);
        check_val("rst bvalid", 32'(bvalid), 32'd0);
        check_val("rst rvalid", 32'(rvalid), 32'd0);
        check_val("rst rdata", rdata, 32'h0);
        check_regs("rst");
        areset = 1'b0;
        #1;
        check_val("post-rst awready", 32'(awready), 32'd1);
        check_val("post-rst wready", 32'(wready), 32'd1);
        check_val("post-rst arready", 32'(arready), 32'd1);
        @(negedge tb_ACLK);

        // Full-word writes then read back
        for (int i = 0; i < 4; i++) begin
            axi_write(AW'(i * 4), vals[i], 4'hF, rsp);
            check_val($sformatf("wr%0d bresp", i), 32'(rsp), 32'(RESP_OKAY));
            exp_regs[i] = vals[i];
        end
        check_regs("after wr");
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(i * 4), rd, rsp);
            check_val($sformatf("rd%0d data", i), rd, vals[i]);
            check_val($sformatf("rd%0d rresp", i), 32'(rsp), 32'(RESP_OKAY));
        end
        axi_read(5'h0E, rd, rsp);
        check_val("rd 0x0E data", rd, 32'hbeef0011);

        // Byte strobes
        axi_write(5'h00, 32'hFFFFFFFF, 4'hF, rsp);
        axi_write(5'h00, 32'h00000000, 4'b0101, rsp);
        check_val("strb0101 bresp", 32'(rsp), 32'(RESP_OKAY));
        axi_read(5'h00, rd, rsp);
        check_val("strb0101 data", rd, 32'hFF00FF00);
        axi_write(5'h00, 32'h12345678, 4'b0000, rsp);
        check_val("strb0 bresp", 32'(rsp), 32'(RESP_OKAY));
        axi_read(5'h00, rd, rsp);
        check_val("strb0 data", rd, 32'hFF00FF00);
        axi_write(5'h00, 32'hAB000000, 4'b1000, rsp);
        axi_read(5'h00, rd, rsp);
        check_val("strb1000 data", rd, 32'hAB00FF00);
        exp_regs[0] = 32'hAB00FF00;

        // Unmapped accesses
        axi_write(5'h14, 32'hCAFEBABE, 4'hF, rsp);
        check_val("unmapped bresp", 32'(rsp), 32'(RESP_SLVERR));
        check_regs("unmapped wr");
        axi_read(5'h18, rd, rsp);
        check_val("unmapped 0x18 rresp", 32'(rsp), 32'(RESP_SLVERR));
        check_val("unmapped 0x18 rdata", rd, 32'h0);
        axi_read(5'h10, rd, rsp);
        check_val("unmapped 0x10 rresp", 32'(rsp), 32'(RESP_SLVERR));

        // AW three cycles ahead of W
        awaddr = 5'h04; awvalid = 1'b1;
        @(negedge tb_ACLK);
        awvalid = 1'b0;
        repeat (2) @(negedge tb_ACLK);
        check_val("aw-first no commit", 32'(bvalid), 32'd0);
        check_val("aw-first awready", 32'(awready), 32'd0);
        wdata = 32'h5a5a5a5a; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge tb_ACLK);
        wvalid = 1'b0;
        check_val("aw-first bvalid n", 32'(bvalid), 32'd0);
        @(negedge tb_ACLK);
        check_val("aw-first bvalid n+1", 32'(bvalid), 32'd1);
        check_val("aw-first reg1", regs[63:32], 32'h5a5a5a5a);
        bready = 1'b1;
        @(negedge tb_ACLK);
        bready = 1'b0;
        repeat (3) @(negedge tb_ACLK);
        check_val("aw-first single pulse", 32'(bvalid), 32'd0);

        // W three cycles ahead of AW
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge tb_ACLK);
        wvalid = 1'b0;
        repeat (2) @(negedge tb_ACLK);
        check_val("w-first no commit", 32'(bvalid), 32'd0);
        check_val("w-first wready", 32'(wready), 32'd0);
        awaddr = 5'h04; awvalid = 1'b1;
        @(negedge tb_ACLK);
        awvalid = 1'b0;
        check_val("w-first bvalid n", 32'(bvalid), 32'd0);
        @(negedge tb_ACLK);
        check_val("w-first bvalid n+1", 32'(bvalid), 32'd1);
        check_val("w-first bresp", 32'(bresp), 32'(RESP_OKAY));
        check_val("w-first reg1", regs[63:32], 32'h12345678);
        bready = 1'b1;
        @(negedge tb_ACLK);
        bready = 1'b0;
        repeat (3) @(negedge tb_ACLK);
        check_val("w-first single pulse", 32'(bvalid), 32'd0);

        // B backpressure, then AR colliding with the stalled commit
        areset = 1'b1;
        repeat (2) @(negedge tb_ACLK);
        areset = 1'b0;
        @(negedge tb_ACLK);
        awaddr = 5'h00; wdata = 32'h11111111; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge tb_ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge tb_ACLK);
        check_val("bp first bvalid", 32'(bvalid), 32'd1);
        awaddr = 5'h08; wdata = 32'h22222222;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge tb_ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        check_val("bp awready", 32'(awready), 32'd0);
        check_val("bp wready", 32'(wready), 32'd0);
        repeat (9) @(negedge tb_ACLK);
        check_val("bp bvalid held", 32'(bvalid), 32'd1);
        check_val("bp reg2 unchanged", regs[95:64], 32'h0);
        check_val("bp awready held", 32'(awready), 32'd0);
        bready = 1'b1;
        @(negedge tb_ACLK);
        bready = 1'b0;
        check_val("bp bvalid gap", 32'(bvalid), 32'd0);
        araddr = 5'h08; arvalid = 1'b1;
        @(negedge tb_ACLK);
        arvalid = 1'b0;
        check_val("collide rvalid", 32'(rvalid), 32'd1);
        check_val("collide rdata pre-write", rdata, 32'h0);
        check_val("collide rresp", 32'(rresp), 32'(RESP_OKAY));
        check_val("collide bvalid", 32'(bvalid), 32'd1);
        check_val("collide arready", 32'(arready), 32'd0);
        check_val("collide reg2", regs[95:64], 32'h22222222);
        check_val("collide reg0", regs[31:0], 32'h11111111);
        repeat (2) @(negedge tb_ACLK);
        check_val("rdata stable", rdata, 32'h0);
        check_val("rvalid stable", 32'(rvalid), 32'd1);
        bready = 1'b1; rready = 1'b1;
        @(negedge tb_ACLK);
        bready = 1'b0; rready = 1'b0;
        check_val("collide bvalid clr", 32'(bvalid), 32'd0);
        check_val("collide rvalid clr", 32'(rvalid), 32'd0);

        // Reset with AW captured and W pending
        awaddr = 5'h04; awvalid = 1'b1;
        @(negedge tb_ACLK);
        awvalid = 1'b0;
        check_val("mid awready", 32'(awready), 32'd0);
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        areset = 1'b1;
        #1;
        check_val("in-rst wready", 32'(wready), 32'd0);
        check_val("in-rst arready", 32'(arready), 32'd0);
        @(negedge tb_ACLK);
        @(negedge tb_ACLK);
        areset = 1'b0; wvalid = 1'b0;
        #1;
        for (int i = 0; i < int'(NR); i++) exp_regs[i] = 32'h0;
        check_val("rel awready", 32'(awready), 32'd1);
        check_val("rel wready", 32'(wready), 32'd1);
        check_val("rel arready", 32'(arready), 32'd1);
        check_val("rel bvalid", 32'(bvalid), 32'd0);
        check_regs("rel");
        @(negedge tb_ACLK);
        repeat (3) @(negedge tb_ACLK);
        check_val("rel no commit", 32'(bvalid), 32'd0);
        check_regs("rel later");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
